game_sequencer: RTL and testbench

Top-level game-flow controller for the balance board. It debounces the run and pause slide switches and steps the game through select, countdown, play, pause and finish states. It latches the map chosen during selection, gates the ball-physics datapath, and keeps the play-time counter shown on the display. All switch handling is synchronous to `clk`; no switch drives a clock pin.

---
 rtl/game_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for the balance board: switch debouncing plus the select/count/play/pause/finish FSM.
// Define GAME_TIMEOUT_EN to end play as a loss once the elapsed seconds reach TIME_LIMIT.
module game_sequencer #(
   parameter int DB_CYCLES  = 1000000,
   parameter int COUNTDOWN  = 3,
   parameter int TIME_LIMIT = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       sw_run,
   input  logic       sw_pause,
   input  logic       goal,
   input  logic       fall,
   input  logic [1:0] map_sel,
   output logic [2:0] state,
   output logic       selecting,
   output logic       load,
   output logic       run,
   output logic [1:0] map_q,
   output logic [6:0] seconds,
   output logic [1:0] result
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
   localparam logic [6:0] CD_START = 7'(COUNTDOWN);

   typedef enum logic [2:0] {
      S_SELECT = 3'd0,
      S_COUNT  = 3'd1,
      S_PLAY   = 3'd2,
      S_PAUSE  = 3'd3,
      S_WIN    = 3'd4,
      S_LOSE   = 3'd5
   } state_t;

   logic [1:0] w_sw_raw;
   logic [1:0] w_db;
   logic       w_timeout;

   assign w_sw_raw = {sw_pause, sw_run};

   // Bit 0 is the run switch, bit 1 the pause switch.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_db
         logic          r_s1;
         logic          r_s2;
         logic          r_db;
         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_s1  <= 1'b0;
               r_s2  <= 1'b0;
               r_db  <= 1'b0;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_sw_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_db) begin
                  r_cnt <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_db  <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
         end

         assign w_db[gi] = r_db;
      end
   endgenerate

   logic r_run_db_q;
   logic r_run_rise;
   logic r_run_fall;
   logic r_pause_db;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run_db_q <= 1'b0;
         r_run_rise <= 1'b0;
         r_run_fall <= 1'b0;
         r_pause_db <= 1'b0;
      end else begin
         r_run_db_q <= w_db[0];
         r_run_rise <= w_db[0] & ~r_run_db_q;
         r_run_fall <= ~w_db[0] & r_run_db_q;
         r_pause_db <= w_db[1];
      end
   end

   state_t     r_state;
   logic       r_selecting;
   logic       r_load;
   logic       r_run;
   logic [1:0] r_map_q;
   logic [6:0] r_seconds;
   logic [1:0] r_result;

`ifdef GAME_TIMEOUT_EN
   localparam logic [6:0] LIMIT = 7'(TIME_LIMIT);
   assign w_timeout = tick_1hz && (r_seconds == LIMIT - 7'd1);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_SELECT;
         r_selecting <= 1'b1;
         r_load      <= 1'b0;
         r_run       <= 1'b0;
         r_map_q     <= 2'd0;
         r_seconds   <= 7'd0;
         r_result    <= 2'd0;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            S_SELECT: begin
               if (r_run_rise) begin
                  r_map_q     <= (map_sel == 2'd3) ? 2'd0 : map_sel;
                  r_seconds   <= CD_START;
                  r_load      <= 1'b1;
                  r_selecting <= 1'b0;
                  r_state     <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (r_run_fall) begin
                  r_selecting <= 1'b1;
                  r_state     <= S_SELECT;
               end else if (tick_1hz) begin
                  if (r_seconds == 7'd1) begin
                     r_seconds <= 7'd0;
                     r_run     <= 1'b1;
                     r_state   <= S_PLAY;
                  end else begin
                     r_seconds <= r_seconds - 7'd1;
                  end
               end
            end
            S_PLAY: begin
               // Any exit from PLAY swallows a coincident tick (timeout sets the limit explicitly).
               if (r_run_fall) begin
                  r_run       <= 1'b0;
                  r_selecting <= 1'b1;
                  r_state     <= S_SELECT;
               end else if (goal) begin
                  r_run    <= 1'b0;
                  r_result <= 2'b01;
                  r_state  <= S_WIN;
               end else if (fall || w_timeout) begin
                  r_run    <= 1'b0;
                  r_result <= 2'b10;
                  r_state  <= S_LOSE;
                  if (!fall)
                     r_seconds <= r_seconds + 7'd1;
               end else if (r_pause_db) begin
                  r_run   <= 1'b0;
                  r_state <= S_PAUSE;
               end else if (tick_1hz && r_seconds != 7'd127) begin
                  r_seconds <= r_seconds + 7'd1;
               end
            end
            S_PAUSE: begin
               if (r_run_fall) begin
                  r_selecting <= 1'b1;
                  r_state     <= S_SELECT;
               end else if (!r_pause_db) begin
                  r_run   <= 1'b1;
                  r_state <= S_PLAY;
               end
            end
            S_WIN, S_LOSE: begin
               if (r_run_fall) begin
                  r_result    <= 2'b00;
                  r_selecting <= 1'b1;
                  r_state     <= S_SELECT;
               end
            end
            default: begin
               r_run       <= 1'b0;
               r_selecting <= 1'b1;
               r_result    <= 2'b00;
               r_state     <= S_SELECT;
            end
         endcase
      end
   end

   assign state     = r_state;
   assign selecting = r_selecting;
   assign load      = r_load;
   assign run       = r_run;
   assign map_q     = r_map_q;
   assign seconds   = r_seconds;
   assign result    = r_result;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with DB_CYCLES=4, COUNTDOWN=3, TIME_LIMIT=5.
// Follows GAME_TIMEOUT_EN the same way as the design build.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       sw_run = 1'b0;
   logic       sw_pause = 1'b0;
   logic       goal = 1'b0;
   logic       fall = 1'b0;
   logic [1:0] map_sel = 2'd0;
   logic [2:0] state;
   logic       selecting;
   logic       load;
   logic       run;
   logic [1:0] map_q;
   logic [6:0] seconds;
   logic [1:0] result;

   int n_checks = 0;
   int n_errors = 0;

   game_sequencer #(
      .DB_CYCLES (4),
      .COUNTDOWN (3),
      .TIME_LIMIT(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_1hz (tick_1hz),
      .sw_run   (sw_run),
      .sw_pause (sw_pause),
      .goal     (goal),
      .fall     (fall),
      .map_sel  (map_sel),
      .state    (state),
      .selecting(selecting),
      .load     (load),
      .run      (run),
      .map_q    (map_q),
      .seconds  (seconds),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] exp);
      for (int i = 0; i < 30 && state != exp; i++) step();
      check(tag, 32'(state), 32'(exp));
   endtask

   initial begin
      // Reset values
      steps(3);
      check("rst_state", 32'(state), 0);
      check("rst_selecting", 32'(selecting), 1);
      check("rst_run", 32'(run), 0);
      check("rst_load", 32'(load), 0);
      check("rst_map_q", 32'(map_q), 0);
      check("rst_seconds", 32'(seconds), 0);
      check("rst_result", 32'(result), 0);
      rst = 1'b1;
      steps(2);

      // Short bounce is rejected
      map_sel = 2'd2;
      sw_run = 1'b1;
      steps(2);
      sw_run = 1'b0;
      steps(12);
      check("bounce_state", 32'(state), 0);

      // Stable run switch starts a game
      sw_run = 1'b1;
      wait_state("start_state", 3'd1);
      check("start_load", 32'(load), 1);
      check("start_map_q", 32'(map_q), 2);
      check("start_seconds", 32'(seconds), 3);
      check("start_selecting", 32'(selecting), 0);
      step();
      check("load_one_cycle", 32'(load), 0);

      // Countdown
      tick();
      check("cd_2", 32'(seconds), 2);
      tick();
      check("cd_1", 32'(seconds), 1);
      tick();
      check("play_state", 32'(state), 2);
      check("play_run", 32'(run), 1);
      check("play_seconds0", 32'(seconds), 0);
      tick();
      tick();
      check("play_seconds2", 32'(seconds), 2);

      // goal beats fall; coincident tick not counted
      goal = 1'b1;
      fall = 1'b1;
      tick();
      goal = 1'b0;
      fall = 1'b0;
      check("win_state", 32'(state), 4);
      check("win_result", 32'(result), 1);
      check("win_run", 32'(run), 0);
      check("win_seconds", 32'(seconds), 2);
      sw_run = 1'b0;
      wait_state("win_to_select", 3'd0);
      check("sel_result", 32'(result), 0);
      check("sel_seconds_held", 32'(seconds), 2);
      check("sel_selecting", 32'(selecting), 1);

      // Map 3 latches as 0; pause freezes time
      map_sel = 2'd3;
      sw_run = 1'b1;
      wait_state("g2_count", 3'd1);
      check("g2_map_q", 32'(map_q), 0);
      steps(2);
      tick();
      tick();
      tick();
      check("g2_play", 32'(state), 2);
      tick();
      check("g2_sec1", 32'(seconds), 1);
      sw_pause = 1'b1;
      wait_state("pause_state", 3'd3);
      check("pause_run", 32'(run), 0);
      tick();
      tick();
      goal = 1'b1;
      tick();
      goal = 1'b0;
      check("pause_frozen", 32'(seconds), 1);
      check("pause_ignores_goal", 32'(state), 3);
      sw_pause = 1'b0;
      wait_state("resume_state", 3'd2);
      check("resume_run", 32'(run), 1);
      tick();
      check("resume_count", 32'(seconds), 2);

`ifdef GAME_TIMEOUT_EN
      tick();
      tick();
      check("to_sec4", 32'(seconds), 4);
      check("to_still_play", 32'(state), 2);
      tick();
      check("to_state", 32'(state), 5);
      check("to_result", 32'(result), 2);
      check("to_seconds", 32'(seconds), 5);
      check("to_run", 32'(run), 0);
`else
      for (int i = 0; i < 130; i++) tick();
      check("sat_state", 32'(state), 2);
      check("sat_seconds", 32'(seconds), 127);
      fall = 1'b1;
      step();
      fall = 1'b0;
      check("fall_state", 32'(state), 5);
      check("fall_result", 32'(result), 2);
      check("fall_run", 32'(run), 0);
`endif
      sw_run = 1'b0;
      wait_state("lose_to_select", 3'd0);
      check("lose_clr_result", 32'(result), 0);

      // Third game, then asynchronous reset during PLAY
      map_sel = 2'd1;
      sw_run = 1'b1;
      wait_state("g3_count", 3'd1);
      check("g3_map_q", 32'(map_q), 1);
      tick();
      tick();
      tick();
      tick();
      check("g3_sec1", 32'(seconds), 1);
      check("g3_play", 32'(state), 2);
      rst = 1'b0;
      #2;
      check("arst_state", 32'(state), 0);
      check("arst_run", 32'(run), 0);
      check("arst_seconds", 32'(seconds), 0);
      check("arst_map_q", 32'(map_q), 0);
      check("arst_selecting", 32'(selecting), 1);
      step();
      rst = 1'b1;

      // run switch already high at reset release starts a game after debounce
      step();
      check("post_rst_select", 32'(state), 0);
      wait_state("post_rst_count", 3'd1);
      check("post_rst_load", 32'(load), 1);
      check("post_rst_map_q", 32'(map_q), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
